// File: rtl/agg_seq.sv
// Round-robin partial-sum aggregator: collects term_cnt signed terms from REQS lanes into one N-bit result.
// Build option AGG_SEQ_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module agg_seq #(
  parameter int N    = 12,
  parameter int REQS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        term_cnt,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*N-1:0] req_data,
  output logic [REQS-1:0]   gnt,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);

  localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [N-1:0]    acc_r;
  logic [7:0]      cnt_r;
  logic [7:0]      tc_r;
  logic [PW-1:0]   ptr_r;
  logic            ovf_r;

  logic [REQS-1:0] gnt_s;
  logic [PW-1:0]   gidx_s;
  logic            xfer_s;
  logic [N-1:0]    gdata_s;
  logic [N-1:0]    sum_s;
  logic [N-1:0]    acc_add_s;
  logic            add_ovf_s;
  logic            last_s;
  logic [PW-1:0]   ptr_nxt_s;

  // Two's-complement overflow: operands agree in sign but the sum does not.
  function automatic logic add_overflow(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic [N-1:0] s);
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  function automatic logic [N-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction

  // Round-robin arbiter: first requesting lane at or after the priority pointer.
  always_comb begin
    int  lane_v;
    logic found_v;
    gnt_s   = '0;
    gidx_s  = '0;
    found_v = 1'b0;
    lane_v  = 0;
    if (state_r == ST_ACCUM) begin
      for (int k = 0; k < REQS; k++) begin
        lane_v = int'(ptr_r) + k;
        if (lane_v >= REQS) begin
          lane_v = lane_v - REQS;
        end else begin
          lane_v = lane_v;
        end
        if (!found_v && req[lane_v]) begin
          gnt_s[lane_v] = 1'b1;
          gidx_s        = lane_v[PW-1:0];
          found_v       = 1'b1;
        end else begin
          found_v = found_v;
        end
      end
    end else begin
      gnt_s = '0;
    end
  end

  // Adder, overflow detection and the optional clamp.
  always_comb begin
    xfer_s    = |gnt_s;
    gdata_s   = req_data[int'(gidx_s)*N +: N];
    sum_s     = acc_r + gdata_s;
    add_ovf_s = add_overflow(acc_r, gdata_s, sum_s);
`ifdef AGG_SEQ_SAT_EN
    acc_add_s = add_ovf_s ? sat_value(acc_r[N-1]) : sum_s;
`else
    acc_add_s = sum_s;
`endif
    last_s    = ({1'b0, cnt_r} + 9'd1) == {1'b0, tc_r};
    if (gidx_s == PW'(REQS - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gidx_s + PW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (term_cnt == 8'd0) ? ST_OUT : ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (xfer_s && last_s) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Accumulator, term counter, latched count, pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
      cnt_r <= 8'd0;
      tc_r  <= 8'd0;
      ptr_r <= '0;
      ovf_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      acc_r <= '0;
      cnt_r <= 8'd0;
      tc_r  <= term_cnt;
      ovf_r <= 1'b0;
    end else if (xfer_s) begin
      acc_r <= acc_add_s;
      cnt_r <= cnt_r + 8'd1;
      ovf_r <= ovf_r | add_ovf_s;
      ptr_r <= ptr_nxt_s;
    end
  end

  // Output decode from registered state.
  always_comb begin
    gnt      = gnt_s;
    out_data = acc_r;
    ovf      = ovf_r;
    case (state_r)
      ST_IDLE: begin
        out_valid = 1'b0;
        busy      = 1'b0;
      end
      ST_ACCUM: begin
        out_valid = 1'b0;
        busy      = 1'b1;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/agg_seq.md
AGG_SEQ -- requirements
Module: agg_seq

Interface
REQ-001 The block SHALL have parameter N, default 12, giving the data width in bits (two's complement), matching the aggregator word.
REQ-002 The block SHALL have parameter REQS, default 4, giving the number of requesting ALU lanes (range 2..8).
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset; rst=0 SHALL reset all state immediately, independent of clk.
REQ-005 Port start  input  1  one-cycle pulse that begins aggregation of one neuron.
REQ-006 Port term_cnt  input  8  number of terms to aggregate, sampled when start is accepted.
REQ-007 Port req  input  REQS  per-lane request; lane i holds a valid partial sum.
REQ-008 Port req_data  input  REQS*N  packed partial sums; lane i occupies bits [i*N +: N].
REQ-009 Port gnt  output  REQS  one-hot grant; a term transfers when req[i] and gnt[i] are both 1 in the same cycle.
REQ-010 Port out_valid  output  1  aggregated result available to the activation stage.
REQ-011 Port out_data  output  N  aggregated result.
REQ-012 Port out_ready  input  1  activation stage accepts the result.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port ovf  output  1  sticky overflow flag for the current result; valid while out_valid=1.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and OUT.
REQ-016 IDLE: start=1 SHALL clear the accumulator, the term counter and ovf, latch term_cnt, and go to ACCUM (or to OUT if term_cnt=0).
REQ-017 start SHALL be ignored in ACCUM and OUT.
REQ-018 ACCUM: gnt SHALL be driven combinationally, granting at most one requesting lane per cycle by round-robin from the priority pointer.
REQ-019 The priority pointer SHALL be 0 after reset and SHALL move to (grantee+1) mod REQS after each transfer; with no transfer it SHALL hold.
REQ-020 gnt SHALL be all-zero in IDLE and OUT, and SHALL be all-zero when req=0.
REQ-021 Each transfer SHALL add the granted req_data to the N-bit accumulator (signed) and increment the term counter.
REQ-022 When the transfer brings the count to the latched term_cnt, the next state SHALL be OUT; out_valid SHALL rise in the cycle after the last transfer (latency 1).
REQ-023 OUT: out_valid=1; out_data and ovf SHALL hold stable while out_ready=0.
REQ-024 OUT with out_ready=1 SHALL complete the transfer, return to IDLE, and drop out_valid and busy in the next cycle.
REQ-025 Signed overflow on any add SHALL set ovf, which stays set until the next accepted start.
REQ-026 term_cnt=0 SHALL produce out_data=0 and ovf=0 one cycle after start.
REQ-027 A start in the same cycle as the OUT handshake SHALL be ignored; a new start is accepted only in IDLE.

Reset
REQ-028 While rst=0: state=IDLE, out_valid=0, out_data=0, ovf=0, busy=0, gnt=0, accumulator=0, counter=0, pointer=0.
REQ-029 Reset asserted mid-ACCUM or mid-OUT SHALL abort the operation; the partial result is discarded and not emitted.
REQ-030 The first start SHALL be accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-031 Macro AGG_SEQ_SAT_EN defined: on overflow the accumulator SHALL saturate to +(2^(N-1)-1) or -(2^(N-1)), and later adds continue from the saturated value.
REQ-032 AGG_SEQ_SAT_EN undefined: the accumulator SHALL wrap modulo 2^N; ovf SHALL be flagged in both builds.

Verification
REQ-033 start with term_cnt=3; only lane 0 requests data 5, 6, 7 -> out_valid rises one cycle after the third grant, out_data=18, ovf=0.
REQ-034 start with term_cnt=4; all four lanes request continuously -> grants go lane 0, 1, 2, 3 in order, one per cycle, and the sum is correct.
REQ-035 Sum of 2047 + 1 (N=12) -> ovf=1; out_data=2047 with AGG_SEQ_SAT_EN, -2048 without.
REQ-036 Hold out_ready=0 for 5 cycles in OUT -> out_data stable and busy=1; a start pulse is ignored; out_ready=1 -> IDLE next cycle.
REQ-037 start with term_cnt=0 -> out_valid=1, out_data=0 on the next cycle, and gnt stays 0.
REQ-038 Pulse rst low after 2 of 4 terms -> outputs reset immediately; a new start with term_cnt=1 and data 3 -> out_data=3.
